alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width (legal 8..64).
REQ-002 Parameter: MUL_EN, default 1; 1 enables the iterative MUL; 0 treats MUL encodings as illegal.
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  request valid.
REQ-006 Port: in_ready  output  1  unit can accept a request this cycle.
REQ-007 Port: alu_op  input  2  00 add (load/store/jump), 01 branch compare, 10 R/I decode, 11 reserved.
REQ-008 Port: funct3  input  3  instruction funct3.
REQ-009 Port: funct7  input  7  instruction funct7.
REQ-010 Port: op_a, op_b  input  XLEN each  operands.
REQ-011 Port: out_valid  output  1  result valid; held until consumed.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: result  output  XLEN  operation result.
REQ-014 Port: br_taken  output  1  branch condition true (alu_op 01 only, else 0).
REQ-015 Port: zero  output  1  result == 0.
REQ-016 Port: illegal  output  1  request encoding not supported.

Function
REQ-017 Accept = in_valid & in_ready; operands and controls are captured at accept and never sampled again.
REQ-018 FSM states IDLE, BUSY, HOLD; in_ready = (state==IDLE) | (state==HOLD & out_ready); 0 in BUSY.
REQ-019 alu_op 00: result = op_a + op_b (mod 2^XLEN), funct fields ignored.
REQ-020 alu_op 10, funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
REQ-021 alu_op 10, funct7 0100000: funct3 000 SUB, 101 SRA; any other funct3 illegal.
REQ-022 alu_op 10, funct7 0000001, funct3 000, MUL_EN=1: MUL, low XLEN bits of op_a*op_b; other funct7/funct3 combinations illegal.
REQ-023 Shift amount = op_b[log2(XLEN)-1:0]; SLT/SLTU result 1 or 0 zero-extended.
REQ-024 alu_op 01: result = op_a - op_b; br_taken per funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 illegal.
REQ-025 alu_op 11: illegal.
REQ-026 Illegal request completes as a single-cycle op with result 0, br_taken 0, zero 1, illegal 1.
REQ-027 Single-cycle op accepted at edge N: out_valid=1 with registered result after edge N; state HOLD.
REQ-028 MUL accepted at edge N: state BUSY, shift-add one multiplier bit per cycle; out_valid=1 after edge N+XLEN; state HOLD.
REQ-029 HOLD & out_ready & !in_valid: out_valid=0 next cycle, state IDLE.
REQ-030 HOLD & out_ready & in_valid: back-to-back accept; single-cycle op stays HOLD with new result (out_valid stays 1); MUL goes BUSY (out_valid 0).
REQ-031 HOLD & !out_ready: result, br_taken, zero, illegal, out_valid held stable.
REQ-032 out_ready while out_valid=0 has no effect; in_valid in BUSY is ignored.

Reset
REQ-033 rst_n low asynchronously forces state IDLE, out_valid 0, result 0, br_taken 0, zero 0, illegal 0, multiplier registers 0.
REQ-034 Reset during BUSY aborts the MUL; no result is produced after release.
REQ-035 First accept possible on the first rising edge with rst_n high.

Verification
REQ-036 alu_op 10, funct7 0100000, funct3 000, a=5, b=7, XLEN=32 -> one cycle later out_valid=1, result 0xFFFFFFFE, zero 0.
REQ-037 alu_op 01, funct3 100, a=0xFFFFFFFF, b=1 -> br_taken 1; same with funct3 110 -> br_taken 0.
REQ-038 MUL a=0x10001, b=0x10001 -> in_ready 0 for 32 cycles, out_valid after 32 edges, result 0x00020001.
REQ-039 Back-to-back: ADD 1+2 then SRA 0x80000000>>4 with out_ready=1 -> results 3, 0xF8000000 on consecutive cycles, out_valid continuously 1.
REQ-040 alu_op 11 then funct7 0100000/funct3 001 -> illegal 1, result 0, zero 1 each; out_ready=0 holds outputs for 5 cycles unchanged.
REQ-041 rst_n low at cycle 10 of a MUL -> out_valid 0, state IDLE immediately; after release in_ready 1 and no stale result appears.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle RV32-style ALU and branch compare, plus an
// optional iterative shift-add multiplier. Results sit in HOLD until the consumer takes them.
module alu_exec_unit #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            br_taken,
   output logic            zero,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              br_q, br_d, zero_q, zero_d, ill_q, ill_d, ov_q, ov_d;
   logic [XLEN-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [XLEN-1:0]   op_res;
   logic              op_br, op_ill, op_mul;
   logic [SHW-1:0]    shamt;
   logic              eq, lt_s, lt_u, accept;
   logic [XLEN-1:0]   acc_step;

   assign shamt = op_b[SHW-1:0];
   assign eq    = (op_a == op_b);
   assign lt_s  = ($signed(op_a) < $signed(op_b));
   assign lt_u  = (op_a < op_b);

   // Decode and evaluate the incoming request; only used at the accept edge.
   always_comb begin
      op_res = '0;
      op_br  = 1'b0;
      op_ill = 1'b0;
      op_mul = 1'b0;
      unique case (alu_op)
         2'b00: op_res = op_a + op_b;
         2'b01: begin
            op_res = op_a - op_b;
            case (funct3)
               3'b000:  op_br = eq;
               3'b001:  op_br = ~eq;
               3'b100:  op_br = lt_s;
               3'b101:  op_br = ~lt_s;
               3'b110:  op_br = lt_u;
               3'b111:  op_br = ~lt_u;
               default: op_ill = 1'b1;
            endcase
         end
         2'b10: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  op_res = op_a + op_b;
                  3'b001:  op_res = op_a << shamt;
                  3'b010:  op_res = {{(XLEN-1){1'b0}}, lt_s};
                  3'b011:  op_res = {{(XLEN-1){1'b0}}, lt_u};
                  3'b100:  op_res = op_a ^ op_b;
                  3'b101:  op_res = op_a >> shamt;
                  3'b110:  op_res = op_a | op_b;
                  default: op_res = op_a & op_b;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               op_res = op_a - op_b;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               op_res = $signed(op_a) >>> shamt;
            end else if (funct7 == 7'b0000001 && funct3 == 3'b000 && MUL_EN) begin
               op_mul = 1'b1;
            end else begin
               op_ill = 1'b1;
            end
         end
         default: op_ill = 1'b1;
      endcase
      if (op_ill) begin
         op_res = '0;
         op_br  = 1'b0;
      end
   end

   assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
   assign accept   = in_valid & in_ready;
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      br_d     = br_q;
      zero_d   = zero_q;
      ill_d    = ill_q;
      ov_d     = ov_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1)) begin
               state_d  = HOLD;
               ov_d     = 1'b1;
               result_d = acc_step;
               zero_d   = (acc_step == '0);
               br_d     = 1'b0;
               ill_d    = 1'b0;
            end
         end
         default: begin
            if (accept && op_mul) begin
               state_d  = BUSY;
               ov_d     = 1'b0;
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
            end else if (accept) begin
               state_d  = HOLD;
               ov_d     = 1'b1;
               result_d = op_res;
               br_d     = op_br;
               zero_d   = (op_res == '0);
               ill_d    = op_ill;
            end else if (state_q == HOLD && out_ready) begin
               state_d = IDLE;
               ov_d    = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         br_q     <= 1'b0;
         zero_q   <= 1'b0;
         ill_q    <= 1'b0;
         ov_q     <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         br_q     <= br_d;
         zero_q   <= zero_d;
         ill_q    <= ill_d;
         ov_q     <= ov_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = ov_q;
   assign result    = result_q;
   assign br_taken  = br_q;
   assign zero      = zero_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random requests
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [1:0]      alu_op = '0;
   logic [2:0]      funct3 = '0;
   logic [6:0]      funct7 = '0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            br_taken;
   logic            zero;
   logic            illegal;

   int n_checks = 0;
   int n_pass   = 0;

   alu_exec_unit #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .br_taken(br_taken), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference semantics written directly from the instruction rules.
   function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic br,
                                 output logic ill, output logic mul);
      int sa, sb;
      int unsigned sh;
      logic [63:0] prod;
      sa = a; sb = b; sh = int'(b[4:0]);
      r = '0; br = 1'b0; ill = 1'b0; mul = 1'b0;
      case (op)
         2'd0: r = a + b;
         2'd1: begin
            r = a - b;
            case (f3)
               3'd0: br = (a == b);
               3'd1: br = (a != b);
               3'd4: br = (sa < sb);
               3'd5: br = (sa >= sb);
               3'd6: br = (a < b);
               3'd7: br = (a >= b);
               default: ill = 1'b1;
            endcase
         end
         2'd2: begin
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: r = a + b;
                  3'd1: r = a << sh;
                  3'd2: r = {31'b0, sa < sb};
                  3'd3: r = {31'b0, a < b};
                  3'd4: r = a ^ b;
                  3'd5: r = a >> sh;
                  3'd6: r = a | b;
                  default: r = a & b;
               endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5) r = a[31] ? ~((~a) >> sh) : (a >> sh);
            else if (f7 == 7'h01 && f3 == 3'd0) begin
               mul = 1'b1;
               prod = {32'b0, a} * {32'b0, b};
               r = prod[31:0];
            end else ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin r = '0; br = 1'b0; end
   endfunction

   logic [31:0] obs_res;
   logic        obs_br, obs_zero, obs_ill;

   // Issues one request from IDLE, waits for its result, checks it, then drains it.
   task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] er;
      logic eb, ei, em;
      int waitc, busy;
      model(op, f3, f7, a, b, er, eb, ei, em);
      check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom;
      if (em) begin
         waitc = 0; busy = 0;
         while (!out_valid && waitc < 100) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            waitc++;
         end
         check({tag, ".mul_latency"}, 64'(waitc), 64'(XLEN));
         check({tag, ".busy_cycles"}, 64'(busy), 64'(XLEN));
      end
      check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".result"}, 64'(result), 64'(er));
      check({tag, ".br_taken"}, 64'(br_taken), 64'(eb));
      check({tag, ".zero"}, 64'(zero), 64'(er == 32'd0));
      check({tag, ".illegal"}, 64'(illegal), 64'(ei));
      obs_res = result; obs_br = br_taken; obs_zero = zero; obs_ill = illegal;
      $display("txn %s op=%0d f3=%0d f7=%02h a=%08h b=%08h -> result=%08h br=%0b zero=%0b ill=%0b",
               tag, op, f3, f7, a, b, result, br_taken, zero, illegal);
      @(posedge clk); #1;
      check({tag, ".drained"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int stale;
      logic [1:0]  r_op;
      logic [2:0]  r_f3;
      logic [6:0]  r_f7;
      logic [31:0] r_a, r_b;

      #12;
      check("reset.out_valid", 64'(out_valid), 64'd0);
      check("reset.result", 64'(result), 64'd0);
      check("reset.flags", {61'b0, br_taken, zero, illegal}, 64'd0);
      check("reset.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); rst_n = 1'b1;

      // First request is accepted on the very first edge after release.
      do_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, "sub");
      check("sub.literal", 64'(obs_res), 64'hFFFF_FFFE);
      do_op(2'b01, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'd1, "blt");
      check("blt.literal", 64'(obs_br), 64'd1);
      do_op(2'b01, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'd1, "bltu");
      check("bltu.literal", 64'(obs_br), 64'd0);
      do_op(2'b10, 3'b000, 7'h01, 32'h0001_0001, 32'h0001_0001, "mul");
      check("mul.literal", 64'(obs_res), 64'h0002_0001);

      // Back-to-back single-cycle ops with the consumer always ready.
      alu_op = 2'b10; funct7 = 7'h00; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd2;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      check("b2b.valid1", 64'(out_valid), 64'd1);
      check("b2b.result1", 64'(result), 64'd3);
      funct7 = 7'h20; funct3 = 3'b101; op_a = 32'h8000_0000; op_b = 32'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b.valid2", 64'(out_valid), 64'd1);
      check("b2b.result2", 64'(result), 64'hF800_0000);
      @(posedge clk); #1;
      check("b2b.drained", 64'(out_valid), 64'd0);
      $display("txn b2b add 1+2 then sra 80000000>>4");

      // Illegal requests held under back-pressure.
      out_ready = 1'b0; alu_op = 2'b11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("ill11.valid", 64'(out_valid), 64'd1);
         check("ill11.outs", {30'b0, result, br_taken, zero, illegal}, 64'b011);
         check("ill11.in_ready", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b1; alu_op = 2'b10; funct7 = 7'h20; funct3 = 3'b001;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("ill_sub1.valid", 64'(out_valid), 64'd1);
         check("ill_sub1.outs", {30'b0, result, br_taken, zero, illegal}, 64'b011);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("ill.drained", 64'(out_valid), 64'd0);
      $display("txn illegal op11 and f7=20/f3=1 held under back-pressure");

      // Reset in the middle of a multiply aborts it.
      alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd9;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1; rst_n = 1'b0; #1;
      check("mulrst.out_valid", 64'(out_valid), 64'd0);
      check("mulrst.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk); rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("mulrst.no_stale", 64'(stale), 64'd0);
      check("mulrst.ready_after", 64'(in_ready), 64'd1);
      $display("txn reset during mul");

      for (int t = 0; t < 40; t++) begin
         r_op = 2'($urandom_range(0, 3));
         r_f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: r_f7 = 7'h00;
            1: r_f7 = 7'h20;
            2: r_f7 = 7'h01;
            default: r_f7 = 7'($urandom_range(0, 127));
         endcase
         r_a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         r_b = ($urandom_range(0, 4) == 0) ? r_a : $urandom;
         do_op(r_op, r_f3, r_f7, r_a, r_b, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
